// File: rtl/riscv_trap_pkg.sv
// Shared types and constants for the commit-stage trap/retire controller.
package riscv_trap_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSave,
        StRedirect,
        StDrain
    } trap_state_e;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [4:0] EXC_ECALL_M    = 5'd11;
    localparam logic [4:0] EXC_BREAKPOINT = 5'd3;

endpackage

// File: rtl/riscv_commit_trap_ctrl.sv
// Commit-stage trap/retire controller: gates regfile writes, owns mepc/mcause/mtval,
// sequences flush/redirect/drain and counts retired instructions.
module riscv_commit_trap_ctrl
    import riscv_trap_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 10,
    parameter int unsigned XLEN         = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] com_pc_i,
    input  logic [31:0]     com_inst_i,
    input  logic [4:0]      com_rd_addr_i,
    input  logic            com_wr_en_i,
    input  logic            com_valid_i,
    input  logic            com_exc_valid_i,
    input  logic [4:0]      com_exc_cause_i,
    input  logic [XLEN-1:0] com_exc_tval_i,
    input  logic [XLEN-1:0] mtvec_i,
    output logic            retire_wr_en_o,
    output logic            retire_valid_o,
    output logic            flush_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mcause_o,
    output logic [XLEN-1:0] mtval_o,
    output logic [63:0]     minstret_o,
    output logic            busy_o
);

    localparam int unsigned CntW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    trap_state_e     state_q;
    logic [CntW-1:0] drain_cnt_q;
    logic            flush_q, redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q, mepc_q, mcause_q, mtval_q;
    logic [63:0]     minstret_q;

    logic            take, is_ecall, is_ebreak, is_mret;
    logic            trap_detect, mret_detect;
    logic [XLEN-1:0] trap_cause, trap_tval;

    assign take        = com_valid_i & (state_q == StIdle);
    assign is_ecall    = (com_inst_i == INST_ECALL);
    assign is_ebreak   = (com_inst_i == INST_EBREAK);
    assign is_mret     = (com_inst_i == INST_MRET);
    assign trap_detect = take & (com_exc_valid_i | is_ecall | is_ebreak);
    assign mret_detect = take & ~com_exc_valid_i & is_mret;

    assign retire_valid_o = take & ~trap_detect;
    assign retire_wr_en_o = retire_valid_o & com_wr_en_i & (com_rd_addr_i != 5'd0);

    // Upstream exception outranks ECALL, which outranks EBREAK.
    always_comb begin
        trap_cause = XLEN'(com_exc_cause_i);
        trap_tval  = com_exc_tval_i;
        if (!com_exc_valid_i) begin
            if (is_ecall) begin
                trap_cause = XLEN'(EXC_ECALL_M);
                trap_tval  = '0;
            end else begin
                trap_cause = XLEN'(EXC_BREAKPOINT);
                trap_tval  = com_pc_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            drain_cnt_q      <= '0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            mepc_q           <= '0;
            mcause_q         <= '0;
            mtval_q          <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (trap_detect) begin
                        mepc_q   <= com_pc_i;
                        mcause_q <= trap_cause;
                        mtval_q  <= trap_tval;
                        flush_q  <= 1'b1;
                        state_q  <= StSave;
                    end else if (mret_detect) begin
                        flush_q          <= 1'b1;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= mepc_q;
                        state_q          <= StRedirect;
                    end
                end
                StSave: begin
                    redirect_valid_q <= 1'b1;
                    redirect_pc_q    <= {mtvec_i[XLEN-1:2], 2'b00};
                    state_q          <= StRedirect;
                end
                StRedirect: begin
                    redirect_valid_q <= 1'b0;
                    if (DRAIN_CYCLES == 0) begin
                        flush_q <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        drain_cnt_q <= CntW'(DRAIN_CYCLES - 1);
                        state_q     <= StDrain;
                    end
                end
                StDrain: begin
                    if (drain_cnt_q == '0) begin
                        flush_q <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            minstret_q <= '0;
        end else if (retire_valid_o) begin
            minstret_q <= minstret_q + 64'd1;
        end
    end

    assign flush_o          = flush_q;
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign mepc_o           = mepc_q;
    assign mcause_o         = mcause_q;
    assign mtval_o          = mtval_q;
    assign minstret_o       = minstret_q;
    assign busy_o           = (state_q != StIdle);

endmodule

// File: tb/tb_riscv_commit_trap_ctrl.sv
// Directed bench for riscv_commit_trap_ctrl with a queue of expected CSR/redirect values.
module tb_riscv_commit_trap_ctrl;

    localparam int unsigned D = 10;
    localparam logic [31:0] ADD    = 32'h0000_0033;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] com_pc, com_exc_tval, mtvec;
    logic [31:0] com_inst;
    logic [4:0]  com_rd_addr, com_exc_cause;
    logic        com_wr_en, com_valid, com_exc_valid;

    logic        retire_wr_en, retire_valid, flush, redirect_valid, busy;
    logic [63:0] redirect_pc, mepc, mcause, mtval, minstret;
    logic        retire_wr_en0, retire_valid0, flush0, redirect_valid0, busy0;
    logic [63:0] redirect_pc0, mepc0, mcause0, mtval0, minstret0;

    riscv_commit_trap_ctrl #(.DRAIN_CYCLES(D), .XLEN(64)) u_dut (
        .clk(clk), .rst_n(rst_n), .com_pc_i(com_pc), .com_inst_i(com_inst),
        .com_rd_addr_i(com_rd_addr), .com_wr_en_i(com_wr_en), .com_valid_i(com_valid),
        .com_exc_valid_i(com_exc_valid), .com_exc_cause_i(com_exc_cause),
        .com_exc_tval_i(com_exc_tval), .mtvec_i(mtvec), .retire_wr_en_o(retire_wr_en),
        .retire_valid_o(retire_valid), .flush_o(flush), .redirect_valid_o(redirect_valid),
        .redirect_pc_o(redirect_pc), .mepc_o(mepc), .mcause_o(mcause), .mtval_o(mtval),
        .minstret_o(minstret), .busy_o(busy)
    );

    riscv_commit_trap_ctrl #(.DRAIN_CYCLES(0), .XLEN(64)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .com_pc_i(com_pc), .com_inst_i(com_inst),
        .com_rd_addr_i(com_rd_addr), .com_wr_en_i(com_wr_en), .com_valid_i(com_valid),
        .com_exc_valid_i(com_exc_valid), .com_exc_cause_i(com_exc_cause),
        .com_exc_tval_i(com_exc_tval), .mtvec_i(mtvec), .retire_wr_en_o(retire_wr_en0),
        .retire_valid_o(retire_valid0), .flush_o(flush0), .redirect_valid_o(redirect_valid0),
        .redirect_pc_o(redirect_pc0), .mepc_o(mepc0), .mcause_o(mcause0), .mtval_o(mtval0),
        .minstret_o(minstret0), .busy_o(busy0)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_minstret = 0;
    logic [63:0] exp_mepc, exp_mcause, exp_mtval;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input logic [63:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", obs, 64'hx);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic drive(input logic [63:0] pc, input logic [31:0] inst, input logic [4:0] rd,
                         input logic we, input logic exc, input logic [4:0] cause,
                         input logic [63:0] tval);
        com_pc        = pc;
        com_inst      = inst;
        com_rd_addr   = rd;
        com_wr_en     = we;
        com_valid     = 1'b1;
        com_exc_valid = exc;
        com_exc_cause = cause;
        com_exc_tval  = tval;
    endtask

    // Walks cycles N+1 .. first IDLE cycle, checking flush/redirect/busy timing.
    task automatic run_seq(input string tag, input int red_at, input int idle_at,
                           input bit keep, input bit csr_chk);
        for (int k = 1; k <= idle_at; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                if (keep) drive(64'h2000, ADD, 5'd7, 1'b1, 1'b0, 5'd0, 64'd0);
                else com_valid = 1'b0;
            end
            @(negedge clk);
            chk({tag, "_flush"}, 64'(flush), 64'(k < idle_at));
            chk({tag, "_busy"}, 64'(busy), 64'(k < idle_at));
            chk({tag, "_redir_v"}, 64'(redirect_valid), 64'(k == red_at));
            if (redirect_valid) sb_pop(redirect_pc);
            if (csr_chk && k == 1) begin
                sb_pop(mepc);
                sb_pop(mcause);
                sb_pop(mtval);
            end
            if (keep) begin
                chk({tag, "_busy_rv"}, 64'(retire_valid), 64'(k == idle_at));
                chk({tag, "_busy_we"}, 64'(retire_wr_en), 64'(k == idle_at));
                if (k == idle_at) begin
                    chk({tag, "_hold_mepc"}, mepc, exp_mepc);
                    chk({tag, "_hold_mcause"}, mcause, exp_mcause);
                    chk({tag, "_hold_mtval"}, mtval, exp_mtval);
                end
            end
        end
        if (keep) exp_minstret++;
        @(posedge clk); #1;
        com_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_minstret"}, minstret, exp_minstret);
    endtask

    task automatic trap(input string tag, input logic [63:0] pc, input logic [31:0] inst,
                        input logic exc, input logic [4:0] cause, input logic [63:0] tval,
                        input logic [63:0] e_cause, input logic [63:0] e_tval, input bit keep);
        @(posedge clk); #1;
        drive(pc, inst, 5'd3, 1'b1, exc, cause, tval);
        @(negedge clk);
        chk({tag, "_rv"}, 64'(retire_valid), 64'd0);
        chk({tag, "_we"}, 64'(retire_wr_en), 64'd0);
        exp_mepc   = pc;
        exp_mcause = e_cause;
        exp_mtval  = e_tval;
        sb_push({tag, "_mepc"}, pc);
        sb_push({tag, "_mcause"}, e_cause);
        sb_push({tag, "_mtval"}, e_tval);
        sb_push({tag, "_rpc"}, {mtvec[63:2], 2'b00});
        run_seq(tag, 2, D + 3, keep, 1'b1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_flush"}, 64'(flush), 64'd0);
        chk({tag, "_redir_v"}, 64'(redirect_valid), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_rpc"}, redirect_pc, 64'd0);
        chk({tag, "_mepc"}, mepc, 64'd0);
        chk({tag, "_mcause"}, mcause, 64'd0);
        chk({tag, "_mtval"}, mtval, 64'd0);
        chk({tag, "_minstret"}, minstret, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        mtvec = 64'h8000_0003;
        drive(64'd0, ADD, 5'd0, 1'b0, 1'b0, 5'd0, 64'd0);
        com_valid = 1'b0;
        #12;
        chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Retire ADD to x5, then to x0.
        @(posedge clk); #1;
        drive(64'h100, ADD, 5'd5, 1'b1, 1'b0, 5'd0, 64'd0);
        @(negedge clk);
        chk("add_rv", 64'(retire_valid), 64'd1);
        chk("add_we", 64'(retire_wr_en), 64'd1);
        exp_minstret++;
        @(posedge clk); #1;
        drive(64'h104, ADD, 5'd0, 1'b1, 1'b0, 5'd0, 64'd0);
        @(negedge clk);
        chk("add_minstret1", minstret, exp_minstret);
        chk("add0_rv", 64'(retire_valid), 64'd1);
        chk("add0_we", 64'(retire_wr_en), 64'd0);
        exp_minstret++;
        @(posedge clk); #1;
        com_valid = 1'b0;
        @(negedge clk);
        chk("add_minstret2", minstret, exp_minstret);

        trap("ecall", 64'h8000_0100, ECALL, 1'b0, 5'd0, 64'd0, 64'd11, 64'd0, 1'b0);

        // MRET returns to the ECALL pc.
        @(posedge clk); #1;
        drive(64'h8000_0200, MRET, 5'd0, 1'b0, 1'b0, 5'd0, 64'd0);
        @(negedge clk);
        chk("mret_rv", 64'(retire_valid), 64'd1);
        exp_minstret++;
        sb_push("mret_rpc", 64'h8000_0100);
        run_seq("mret", 1, D + 2, 1'b0, 1'b0);

        trap("exc", 64'h1000, EBREAK, 1'b1, 5'd2, 64'hDEAD, 64'd2, 64'hDEAD, 1'b1);
        trap("ebreak", 64'h40, EBREAK, 1'b0, 5'd0, 64'd0, 64'd3, 64'h40, 1'b0);

        // Reset in the middle of DRAIN.
        @(posedge clk); #1;
        drive(64'h8000_0300, ECALL, 5'd0, 1'b0, 1'b0, 5'd0, 64'd0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            com_valid = 1'b0;
        end
        #2;
        chk("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        exp_minstret = 0;
        trap("fresh", 64'h8000_0400, ECALL, 1'b0, 5'd0, 64'd0, 64'd11, 64'd0, 1'b0);

        // Zero-drain build: REDIRECT straight back to IDLE.
        @(posedge clk); #1;
        drive(64'h8000_0500, ECALL, 5'd0, 1'b0, 1'b0, 5'd0, 64'd0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            com_valid = 1'b0;
            @(negedge clk);
            chk("d0_flush", 64'(flush0), 64'(k < 3));
            chk("d0_busy", 64'(busy0), 64'(k < 3));
            chk("d0_redir_v", 64'(redirect_valid0), 64'(k == 2));
            if (k == 2) chk("d0_rpc", redirect_pc0, 64'h8000_0000);
        end

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_commit_trap_ctrl.md
Name: riscv_commit_trap_ctrl

Overview:
- Trap and retire controller attached to the commit (COM) stage of the 10-stage RV64I pipeline.
- Watches each committing instruction and decides one of three outcomes: retire it, trap it (ecall, ebreak, or an upstream-flagged exception), or return from a trap (mret).
- Gates the architectural register-file write and owns mepc/mcause/mtval.
- Sequences the flush, PC redirect and pipeline drain through an FSM, and keeps the 64-bit minstret counter.

Parameters:
- DRAIN_CYCLES, 10, cycles flush stays asserted after redirect so in-flight stages empty (0 allowed).
- XLEN, 64, architectural data and PC width.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- com_pc  input  XLEN  PC of committing instruction
- com_inst  input  32  committing instruction word
- com_rd_addr  input  5  destination register
- com_wr_en  input  1  instruction writes rd
- com_valid  input  1  committing instruction is valid
- com_exc_valid  input  1  upstream exception attached to this instruction
- com_exc_cause  input  5  upstream exception code
- com_exc_tval  input  XLEN  upstream trap value
- mtvec  input  XLEN  trap vector base (direct mode only)
- retire_wr_en  output  1  regfile write enable, combinational
- retire_valid  output  1  instruction retired this cycle, combinational
- flush  output  1  squash all younger pipeline stages
- redirect_valid  output  1  one-cycle fetch redirect
- redirect_pc  output  XLEN  redirect target
- mepc, mcause, mtval  output  XLEN each  trap CSRs
- minstret  output  64  retired-instruction count
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset, asynchronous, active-low:
  - FSM enters IDLE.
  - flush, redirect_valid and busy are 0.
  - redirect_pc, mepc, mcause, mtval and minstret are 0.
  - Reset mid-sequence aborts the sequence immediately; no partial CSR update survives.
- Decode, evaluated only when com_valid=1 and state is IDLE:
  - ECALL = 0x00000073
  - EBREAK = 0x00100073
  - MRET = 0x30200073
- Trap priority: com_exc_valid > ECALL > EBREAK. MRET is honoured only when no exception is present.
- Trap cause and value:
  - Upstream exception: mcause = zero-extended com_exc_cause, mtval = com_exc_tval.
  - ECALL: mcause = 11, mtval = 0.
  - EBREAK: mcause = 3, mtval = com_pc.
  - The interrupt bit (mcause[63]) is always 0.
- Retire gating, combinational, same cycle as the input:
  - retire_valid = com_valid & IDLE & ~trap_detect.
  - retire_wr_en = retire_valid & com_wr_en & (com_rd_addr != 0).
  - MRET retires; trapping instructions never retire.
  - minstret increments by 1 on the following clock edge when retire_valid=1 and wraps at 2^64-1 to 0.
- FSM states: IDLE, SAVE, REDIRECT, DRAIN.
  - IDLE, trap detected at cycle N: capture mepc = com_pc, plus mcause and mtval, on edge N; go to SAVE.
  - IDLE, MRET at cycle N: go to REDIRECT with target = current mepc.
  - SAVE (cycle N+1): flush=1; go to REDIRECT.
  - REDIRECT: flush=1, redirect_valid=1 for exactly one cycle.
    - redirect_pc = {mtvec[XLEN-1:2], 2'b00} for a trap, mepc for MRET.
    - Go to DRAIN, or to IDLE if DRAIN_CYCLES=0.
  - DRAIN: flush=1; a down-counter loaded with DRAIN_CYCLES-1 decrements each cycle; go to IDLE when it reaches 0.
- Latencies:
  - Trap: redirect at N+2; first IDLE cycle at N+3+DRAIN_CYCLES.
  - MRET: redirect at N+1; first IDLE cycle at N+2+DRAIN_CYCLES.
- While busy=1, all com_valid inputs are ignored: no retire, no CSR write, no minstret increment.
- Back-to-back: an instruction arriving in the first IDLE cycle after a sequence is processed normally.
- redirect_pc holds its last value when redirect_valid=0.

Decomposition:
- Package riscv_trap_pkg:
  - State enum trap_state_e.
  - Instruction constants INST_ECALL, INST_EBREAK, INST_MRET.
  - Cause constants EXC_ECALL_M=11, EXC_BREAKPOINT=3.
- No sub-module. The drain counter and minstret counter are inline.

Test Plan:
1. Retire ADD: com_valid=1, com_wr_en=1, rd=5 → retire_wr_en=1 in the same cycle; minstret 0→1. Repeat with rd=0 → retire_wr_en=0, minstret 1→2.
2. ECALL at pc=0x8000_0100, mtvec=0x8000_0003 → retire_wr_en=0; mepc=0x8000_0100, mcause=11, mtval=0; flush high from N+1 through N+2+DRAIN_CYCLES; redirect_valid=1 only at N+2 with redirect_pc=0x8000_0000.
3. Upstream exception plus EBREAK word, com_exc_cause=2, tval=0xDEAD → mcause=2, mtval=0xDEAD (exception wins); EBREAK alone at pc=0x40 → mcause=3, mtval=0x40.
4. MRET after the trap in scenario 2 → retire_valid=1; redirect at N+1 with redirect_pc=0x8000_0100; minstret increments.
5. Valid instructions presented every cycle while busy=1 → no retire_wr_en, no minstret change, CSRs unchanged; instruction in the first IDLE cycle retires.
6. rst_n low during DRAIN → all outputs 0 immediately; after release, an ECALL starts a fresh sequence; DRAIN_CYCLES=0 build goes REDIRECT→IDLE directly.
